// File: rtl/pico_mem_mpu_pkg.sv
// Shared definitions for the picorv32 memory protection unit: FSM encoding,
// protection table field layout and the range helper used by the region checks.
package pico_mem_mpu_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } mpu_state_e;

  localparam int NUM_REGIONS      = 5;
  localparam int WORDS_PER_REGION = 3;

  // Bit positions inside the permission word (W2) and the control word
  localparam int PERM_R      = 0;
  localparam int PERM_W      = 1;
  localparam int PERM_X      = 2;
  localparam int PERM_V      = 3;
  localparam int PERM_BITS   = 4;
  localparam int CTRL_EN_BIT = 0;

  // W0/W1 each pack {base, limit} as two 16-bit halves
  localparam int BASE_LSB  = 16;
  localparam int LIMIT_LSB = 0;
  localparam int FIELD_W   = 16;

  function automatic logic in_range(input logic [FIELD_W-1:0] value,
                                    input logic [FIELD_W-1:0] lo,
                                    input logic [FIELD_W-1:0] hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/pico_mem_mpu_region_check.sv
// Single protection region: data-range match plus owner-PC and R/W/X permission grant.
module mpu_region_check
  import pico_mem_mpu_pkg::*;
(
  input  logic [31:0]          data_word,
  input  logic [31:0]          code_word,
  input  logic [PERM_BITS-1:0] perm_bits,
  input  logic [23:0]          byte_addr,
  input  logic [15:0]          pc_low,
  input  logic                 is_inst,
  input  logic                 is_store,
  output logic                 match,
  output logic                 grant
);

  logic data_hit_s;
  logic code_hit_s;
  logic perm_ok_s;

  // Region hit and the permission required by the access kind
  always_comb begin
    data_hit_s = perm_bits[PERM_V] && (byte_addr[23:16] == 8'd0) &&
                 in_range(byte_addr[15:0], data_word[BASE_LSB +: FIELD_W],
                          data_word[LIMIT_LSB +: FIELD_W]);
    code_hit_s = in_range(pc_low, code_word[BASE_LSB +: FIELD_W],
                          code_word[LIMIT_LSB +: FIELD_W]);
    if (is_inst) begin
      perm_ok_s = perm_bits[PERM_X];
    end else if (is_store) begin
      perm_ok_s = perm_bits[PERM_W] && code_hit_s;
    end else begin
      perm_ok_s = perm_bits[PERM_R] && code_hit_s;
    end
  end

  assign match = data_hit_s;
  assign grant = data_hit_s && perm_ok_s;

endmodule

// File: rtl/pico_mem_mpu.sv
// MPU between the picorv32 native memory port and a single-port SRAM. Loads its
// protection table from a reserved SRAM window after reset, then gates every access.
module pico_mem_mpu
  import pico_mem_mpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MPU_START_ADDR = 768,
  parameter int MPU_LEN        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    is_inst,
  input  logic [31:0]             pc_addr,
  output logic                    inform_cpu_wait,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic [21:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic [DATA_WIDTH/8-1:0] mem_wen,
  output logic [21:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int          CNT_W  = $clog2(MPU_LEN + 1);
  localparam int          IDX_W  = $clog2(MPU_LEN);
  localparam logic [21:0] WIN_LO = 22'(MPU_START_ADDR);
  localparam logic [21:0] WIN_HI = 22'(MPU_START_ADDR + MPU_LEN);

  mpu_state_e            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  wait_r;
  logic                  ready_r;
  logic                  allowed_r;
  logic [DATA_WIDTH-1:0] cfg_r [MPU_LEN];

  logic [IDX_W-1:0]       cfg_idx_s;
  logic [23:0]            byte_addr_s;
  logic                   is_store_s;
  logic                   window_hit_s;
  logic                   allowed_s;
  logic [NUM_REGIONS-1:0] match_s;
  logic [NUM_REGIONS-1:0] grant_s;
  logic                   unused_s;

  assign cfg_idx_s    = IDX_W'(cnt_r - CNT_W'(1));
  assign byte_addr_s  = {cpu_addr, 2'b00};
  assign is_store_s   = |cpu_wstrb;
  assign window_hit_s = (cpu_addr >= WIN_LO) && (cpu_addr < WIN_HI);

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    mpu_region_check u_check (
      .data_word (cfg_r[1 + WORDS_PER_REGION*k]),
      .code_word (cfg_r[2 + WORDS_PER_REGION*k]),
      .perm_bits (cfg_r[3 + WORDS_PER_REGION*k][PERM_BITS-1:0]),
      .byte_addr (byte_addr_s),
      .pc_low    (pc_addr[15:0]),
      .is_inst   (is_inst),
      .is_store  (is_store_s),
      .match     (match_s[k]),
      .grant     (grant_s[k])
    );
  end

  // Access decision; the config window is never writable, even with the MPU off
  always_comb begin
    if (is_store_s && window_hit_s) begin
      allowed_s = 1'b0;
    end else if (!cfg_r[0][CTRL_EN_BIT]) begin
      allowed_s = 1'b1;
    end else if (!(|match_s)) begin
      allowed_s = 1'b1;
    end else begin
      allowed_s = |grant_s;
    end
  end

  // Table bits with no function in the decision
  always_comb begin
    unused_s = ^{cfg_r[0][DATA_WIDTH-1:1], pc_addr[31:16]};
    for (int k = 0; k < NUM_REGIONS; k++) begin
      unused_s = unused_s ^ (^cfg_r[3 + WORDS_PER_REGION*k][DATA_WIDTH-1:PERM_BITS]);
    end
  end

  // SRAM port steering: table fetch during LOAD, pass-through afterwards
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wen   = '0;
    case (state_r)
      ST_LOAD: mem_addr = WIN_LO + 22'(cnt_r);
      ST_IDLE: begin
        if (cpu_valid && allowed_s) begin
          mem_wen = cpu_wstrb;
        end else begin
          mem_wen = '0;
        end
      end
      ST_RESP: mem_wen = '0;
      default: mem_wen = '0;
    endcase
  end

  // SRAM read data is already registered, so the response only needs masking
  assign cpu_rdata       = (state_r == ST_RESP && allowed_r) ? mem_rdata : '0;
  assign cpu_ready       = ready_r;
  assign inform_cpu_wait = wait_r;

  // Control FSM and protection table capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_LOAD;
      cnt_r     <= '0;
      wait_r    <= 1'b1;
      ready_r   <= 1'b0;
      allowed_r <= 1'b0;
      for (int i = 0; i < MPU_LEN; i++) begin
        cfg_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          ready_r <= 1'b0;
          if (cnt_r != CNT_W'(0)) begin
            cfg_r[cfg_idx_s] <= mem_rdata;
          end
          if (cnt_r == CNT_W'(MPU_LEN)) begin
            state_r <= ST_IDLE;
            wait_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (cpu_valid) begin
            allowed_r <= allowed_s;
            ready_r   <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            ready_r <= 1'b0;
          end
        end
        ST_RESP: begin
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_LOAD;
          cnt_r   <= '0;
          wait_r  <= 1'b1;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pico_mem_mpu.sv
// Scoreboard bench for pico_mem_mpu: SRAM model, rule-level reference model,
// directed table scenarios and randomized accesses.
module tb_pico_mem_mpu;

  localparam int START = 768;
  localparam int LEN   = 16;
  localparam int MEMW  = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        is_inst;
  logic [31:0] pc_addr;
  logic        inform_cpu_wait;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [21:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic [3:0]  mem_wen;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'd0;
  logic [31:0] bd_data = 32'd0;

  logic [31:0] sram    [MEMW];
  logic [31:0] ref_mem [MEMW];
  logic [31:0] ref_cfg [LEN];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  pico_mem_mpu dut (
    .clk(clk), .resetn(resetn), .is_inst(is_inst), .pc_addr(pc_addr),
    .inform_cpu_wait(inform_cpu_wait), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM: registered read (old data on a write cycle), byte writes, bench backdoor
  always @(posedge clk) begin
    mem_rdata <= sram[mem_addr[11:0]];
    if (bd_we) begin
      sram[bd_addr] <= bd_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wen[b]) sram[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        check("rdata", cpu_rdata, exp_q.pop_front());
      end
    end
  end

  // Reference decision written directly from the protection rules
  function automatic bit ref_allow(input int waddr, input logic [3:0] strb,
                                   input bit inst, input logic [31:0] pc);
    int a, p, db, dl, cb, cl;
    logic [31:0] dw, cw, pw;
    bit any_match, any_grant, code_ok, need;
    a = waddr * 4;
    p = int'(pc[15:0]);
    any_match = 1'b0;
    any_grant = 1'b0;
    if (strb != 4'd0 && waddr >= START && waddr < START + LEN) return 1'b0;
    if (ref_cfg[0][0] == 1'b0) return 1'b1;
    for (int r = 0; r < 5; r++) begin
      dw = ref_cfg[1 + 3*r];
      cw = ref_cfg[2 + 3*r];
      pw = ref_cfg[3 + 3*r];
      db = int'(dw[31:16]); dl = int'(dw[15:0]);
      cb = int'(cw[31:16]); cl = int'(cw[15:0]);
      if (pw[3] && a >= db && a < dl) begin
        any_match = 1'b1;
        code_ok = (p >= cb) && (p < cl);
        if (inst) need = pw[2];
        else if (strb != 4'd0) need = pw[1] && code_ok;
        else need = pw[0] && code_ok;
        if (need) any_grant = 1'b1;
      end
    end
    return !any_match || any_grant;
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] data);
    bd_addr = 12'(idx);
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  // Reset, program the config window, then follow the table load cycle by cycle
  task automatic reset_and_load(input bit held_fetch);
    resetn    = 1'b0;
    cpu_valid = held_fetch;
    cpu_addr  = 22'd0;
    is_inst   = 1'b1;
    cpu_wstrb = 4'd0;
    cpu_wdata = 32'd0;
    pc_addr   = 32'd0;
    for (int i = 0; i < LEN; i++) begin
      ref_mem[START + i] = ref_cfg[i];
      bd_write(START + i, ref_cfg[i]);
    end
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_wait", 32'(inform_cpu_wait), 32'd1);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(START));
    if (held_fetch) exp_q.push_back(ref_allow(0, 4'd0, 1'b1, 32'd0) ? ref_mem[0] : 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= LEN + 1; k++) begin
      @(posedge clk); #1;
      check("load_wait", 32'(inform_cpu_wait), (k <= LEN) ? 32'd1 : 32'd0);
      check("load_ready", 32'(cpu_ready), 32'd0);
    end
    if (held_fetch) begin
      @(posedge clk); #1;
      check("held_ready", 32'(cpu_ready), 32'd1);
      cpu_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // One access from IDLE: check write enables, queue the response, check timing
  task automatic do_access(input int waddr, input logic [31:0] wd, input logic [3:0] strb,
                           input bit inst, input logic [31:0] pc);
    bit al;
    int idx;
    idx       = waddr % MEMW;
    cpu_addr  = 22'(waddr);
    cpu_wdata = wd;
    cpu_wstrb = strb;
    is_inst   = inst;
    pc_addr   = pc;
    cpu_valid = 1'b1;
    #1;
    al = ref_allow(waddr, strb, inst, pc);
    check("mem_wen", 32'(mem_wen), al ? 32'(strb) : 32'd0);
    exp_q.push_back(al ? ref_mem[idx] : 32'd0);
    if (al) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    check("ready_latency", 32'(cpu_ready), 32'd1);
    cpu_valid = 1'b0;
    cpu_addr  = 22'($urandom_range(0, MEMW - 1));
    cpu_wstrb = 4'($urandom);
    @(posedge clk); #1;
    check("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < MEMW; i++) if (sram[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int waddr, sel, db, cb;
    logic [31:0] pc;
    resetn    = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = 22'd0;
    is_inst   = 1'b0;
    cpu_wstrb = 4'd0;
    cpu_wdata = 32'd0;
    pc_addr   = 32'd0;
    for (int i = 0; i < MEMW; i++) begin
      ref_mem[i] = $urandom;
      bd_write(i, ref_mem[i]);
    end

    // Phase 1: one data region 0x0A00..0x0B00, owners 0..0x100, R+W, no X
    for (int i = 0; i < LEN; i++) ref_cfg[i] = 32'd0;
    ref_cfg[0] = 32'h0000_0001;
    ref_cfg[1] = 32'h0A00_0B00;
    ref_cfg[2] = 32'h0000_0100;
    ref_cfg[3] = 32'h0000_000B;
    reset_and_load(1'b1);
    do_access(32'h281, 32'h1234_5678, 4'hF, 1'b0, 32'h40);
    check("store_ok", sram[32'h281], 32'h1234_5678);
    do_access(32'h281, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h200);
    check("store_denied", sram[32'h281], 32'h1234_5678);
    do_access(32'h281, 32'd0, 4'h0, 1'b0, 32'h200);
    do_access(32'h281, 32'd0, 4'h0, 1'b0, 32'h40);
    do_access(32'h280, 32'd0, 4'h0, 1'b1, 32'h40);
    do_access(32'h0, 32'd0, 4'h0, 1'b1, 32'h40);
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) waddr = $urandom_range(32'h27E, 32'h2C2);
      else if (sel == 1) waddr = $urandom_range(START - 1, START + LEN);
      else if (sel == 2) waddr = $urandom_range(0, 63);
      else waddr = $urandom_range(0, MEMW - 1);
      sel = $urandom_range(0, 2);
      pc = (sel == 0) ? 32'h40 : (sel == 1) ? 32'h200 : 32'($urandom_range(32'hF0, 32'h110));
      do_access(waddr, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                $urandom_range(0, 3) == 0, pc);
    end
    check_image("image_phase1");

    // Phase 2: MPU disabled; only the config window stays write-protected
    ref_cfg[0] = 32'h0000_0000;
    reset_and_load(1'b0);
    do_access(32'h300, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h40);
    check("win_store_denied", sram[32'h300], 32'h0000_0000);
    do_access(32'h200, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h40);
    check("plain_store", sram[32'h200], 32'h0BAD_F00D);
    do_access(32'h281, 32'h5555_AAAA, 4'h3, 1'b0, 32'h200);
    check_image("image_phase2");

    // Phase 3: random five-region table, random traffic including high addresses
    ref_cfg[0] = 32'h0000_0001;
    for (int r = 0; r < 5; r++) begin
      db = $urandom_range(0, 32'h3000);
      cb = $urandom_range(0, 32'h8000);
      ref_cfg[1 + 3*r] = {16'(db), 16'(db + $urandom_range(0, 32'h1000))};
      ref_cfg[2 + 3*r] = {16'(cb), 16'(cb + $urandom_range(0, 32'h7FFF))};
      ref_cfg[3 + 3*r] = {28'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom)};
    end
    reset_and_load(1'b1);
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) waddr = 32'h4000 + $urandom_range(0, 32'hFFFF);
      else if (sel == 1) waddr = $urandom_range(START, START + LEN - 1);
      else waddr = $urandom_range(0, MEMW - 1);
      do_access(waddr, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                $urandom_range(0, 3) == 0, $urandom);
    end
    check_image("image_phase3");
    check("pending_responses", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
